// File: rtl/mau_pkg.sv
// Shared definitions for the MAU host sequencer: opcode values, instruction
// field positions, FSM state encoding and an opcode extraction helper.
// Ports: none (package).
package mau_pkg;

  localparam int BYTE_W = 8;

  // Instruction byte layout: [7:6] destination BRAM, [5:4] source BRAM, [3:0] opcode
  localparam int DST_MSB = 7;
  localparam int DST_LSB = 6;
  localparam int SRC_MSB = 5;
  localparam int SRC_LSB = 4;
  localparam int OP_MSB  = 3;
  localparam int OP_LSB  = 0;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0100;
  localparam logic [3:0] OP_COPY   = 4'b0101;
  localparam logic [3:0] OP_UNLOAD = 4'b0110;
  localparam logic [3:0] OP_CLEAR  = 4'b0111;
  localparam logic [3:0] OP_ADD    = 4'b1100;
  localparam logic [3:0] OP_SHL    = 4'b1101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_DATA,
    S_ISSUE,
    S_WAIT_BUSY,
    S_STREAM,
    S_CAPTURE,
    S_WAIT_DONE,
    S_SEND
  } state_t;

  function automatic logic [3:0] opcode_of(input logic [BYTE_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/mau_byte_buffer.sv
// Single-port byte buffer holding one matrix: synchronous write, combinational read.
// Ports: clk; we/addr/wdata write side; rdata is mem[addr] in the same cycle.
// Contents are deliberately not reset.
module mau_byte_buffer
  import mau_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mau_host_sequencer.sv
// Host-side sequencer for the MAU: takes instruction + payload bytes from the host,
// issues the instruction, streams LOAD payload / captures UNLOAD results, returns them.
// Ports: rx_* host byte input (valid/ready), tx_* result output (valid/ready),
// host_instruction/data_in/data_out/busy_flag to the MAU, err one-cycle fault pulse.
module mau_host_sequencer
  import mau_pkg::*;
#(
  parameter int MATRIX_DIM   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] host_instruction,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  input  logic       busy_flag,
  output logic       err
);

  localparam int N  = MATRIX_DIM * MATRIX_DIM;
  localparam int AW = $clog2(N);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [AW-1:0] LAST    = AW'(N - 1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
  localparam logic [AW:0]   FULL    = (AW + 1)'(N);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [TW-1:0] TMO_ONE = TW'(1);
  localparam logic [TW-1:0] TMO_MAX = TW'(BUSY_TIMEOUT);

  state_t          state, state_nxt;
  logic [7:0]      instr;
  logic [3:0]      op;
  logic [AW-1:0]   idx;   // LOAD stream read index
  logic [AW:0]     cnt;   // GET_DATA / CAPTURE write count; one extra bit to reach N
  logic [AW-1:0]   k;     // SEND read index
  logic [TW-1:0]   tmo;

  logic            buf_we;
  logic [AW-1:0]   buf_addr;
  logic [7:0]      buf_wdata;
  logic [7:0]      buf_rdata;

  logic            rx_rdy_c, tx_vld_c, err_c;
  logic [7:0]      instr_c, din_c;

  assign op = opcode_of(instr);

  mau_byte_buffer #(.DEPTH(N), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we & ~rst),
    .addr  (buf_addr),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      instr <= 8'h00;
      idx   <= '0;
      cnt   <= '0;
      k     <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          idx <= '0;
          cnt <= '0;
          k   <= '0;
          tmo <= '0;
          if (rx_valid) instr <= rx_byte;
        end
        S_GET_DATA: if (rx_valid) cnt <= cnt + CNT_ONE;
        S_ISSUE: begin
          cnt <= '0;
          tmo <= TMO_ONE;
        end
        // The MAU already consumes/produces a byte in the cycle busy is first seen,
        // so that cycle advances the LOAD read index or the UNLOAD write count.
        S_WAIT_BUSY: begin
          if (busy_flag) begin
            if (op == OP_LOAD)   idx <= idx + IDX_ONE;
            if (op == OP_UNLOAD) cnt <= cnt + CNT_ONE;
          end else begin
            tmo <= tmo + TMO_ONE;
          end
        end
        S_STREAM:  if (busy_flag && idx != LAST) idx <= idx + IDX_ONE;
        S_CAPTURE: if (busy_flag && cnt != FULL) cnt <= cnt + CNT_ONE;
        S_SEND:    if (tx_ready) k <= k + IDX_ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    rx_rdy_c  = 1'b0;
    tx_vld_c  = 1'b0;
    err_c     = 1'b0;
    instr_c   = 8'h00;
    din_c     = 8'h00;
    buf_we    = 1'b0;
    buf_addr  = idx;
    buf_wdata = rx_byte;
    case (state)
      S_IDLE: begin
        rx_rdy_c = 1'b1;
        if (rx_valid) begin
          if (opcode_of(rx_byte) == OP_LOAD)     state_nxt = S_GET_DATA;
          else if (opcode_of(rx_byte) != OP_NOP) state_nxt = S_ISSUE;
        end
      end
      S_GET_DATA: begin
        rx_rdy_c = 1'b1;
        buf_addr = cnt[AW-1:0];
        buf_we   = rx_valid;
        if (rx_valid && cnt[AW-1:0] == LAST) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        instr_c   = instr;
        din_c     = buf_rdata;  // idx is 0 here
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (op == OP_LOAD) din_c = buf_rdata;
        if (busy_flag) begin
          if (op == OP_LOAD) begin
            state_nxt = S_STREAM;
          end else if (op == OP_UNLOAD) begin
            buf_addr  = cnt[AW-1:0];
            buf_wdata = data_out;
            buf_we    = 1'b1;
            state_nxt = S_CAPTURE;
          end else begin
            state_nxt = S_WAIT_DONE;
          end
        end else if (tmo == TMO_MAX) begin
          err_c     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        din_c = buf_rdata;
        if (!busy_flag) begin
          err_c     = (idx != LAST);
          state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        buf_addr  = cnt[AW-1:0];
        buf_wdata = data_out;
        if (busy_flag) begin
          buf_we = (cnt != FULL);  // surplus bytes are dropped
        end else begin
          err_c     = (cnt != FULL);
          state_nxt = S_SEND;
        end
      end
      S_WAIT_DONE: if (!busy_flag) state_nxt = S_IDLE;
      S_SEND: begin
        buf_addr = k;
        tx_vld_c = 1'b1;
        if (tx_ready && k == LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while rst is held, so a mid-transfer reset drops tx at once.
  assign rx_ready         = rx_rdy_c & ~rst;
  assign tx_valid         = tx_vld_c & ~rst;
  assign tx_byte          = tx_valid ? buf_rdata : 8'h00;
  assign host_instruction = rst ? 8'h00 : instr_c;
  assign data_in          = rst ? 8'h00 : din_c;
  assign err              = err_c & ~rst;

endmodule
